// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester winner selection for dmem_arbiter.
// DMEM_ARB_RR_EN: when defined, a tie goes to the port not granted last;
// otherwise port 0 (CPU) always wins a tie and i_last is ignored.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

`ifndef DMEM_ARB_RR_EN
  logic w_unused;
  assign w_unused = i_last;
`endif

  // One-hot grant from the two requests and the previous winner
  always_comb begin
    o_gnt = '0;
    if (i_req0 && i_req1) begin
`ifdef DMEM_ARB_RR_EN
      o_gnt = (i_last == PORT_CPU) ? 2'b10 : 2'b01;
`else
      o_gnt = 2'b01;
`endif
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port data memory.
// Each access takes IDLE -> ACCESS -> RESP; one access per three cycles.
// DMEM_ARB_RR_EN: when defined, ties alternate via a last-grant register.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wd,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wd,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  state_t        r_state;
  state_t        w_next;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_rd0;
  logic [DW-1:0] r_rd1;
  logic [1:0]    w_gnt;
  logic          w_win;
  logic          w_grant;
  logic          w_last;

`ifdef DMEM_ARB_RR_EN
  logic r_last;
  assign w_last = r_last;
`else
  assign w_last = PORT_DMA;
`endif

  rr_arb2 u_arb (
    .i_req0 (p0_req),
    .i_req1 (p1_req),
    .i_last (w_last),
    .o_gnt  (w_gnt)
  );

  assign w_win   = w_gnt[1];
  assign w_grant = (r_state == IDLE) && (|w_gnt);

  // Next-state: a grant starts a fixed three-cycle transaction
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (p0_req || p1_req) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Latch the winner's request; these also drive the memory bus, so they hold between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win  <= PORT_CPU;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_wd   <= '0;
    end else if (w_grant) begin
      r_win  <= w_win;
      r_we   <= w_win ? p1_we   : p0_we;
      r_addr <= w_win ? p1_addr : p0_addr;
      r_wd   <= w_win ? p1_wd   : p0_wd;
    end
  end

  // Capture memory read data into the winner's return register during ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else if (r_state == ACCESS) begin
      if (r_win == PORT_DMA) r_rd1 <= mem_rd;
      else                   r_rd0 <= mem_rd;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the most recent winner for tie-breaking
  always_ff @(posedge clk) begin
    if (rst)          r_last <= PORT_DMA;
    else if (w_grant) r_last <= w_win;
  end
`endif

  // Outputs; reset masks the write strobe in the same cycle so an interrupted store never lands
  always_comb begin
    mem_we   = (r_state == ACCESS) && r_we && !rst;
    mem_addr = r_addr;
    mem_wd   = r_wd;
    p0_ack   = (r_state == RESP) && (r_win == PORT_CPU);
    p1_ack   = (r_state == RESP) && (r_win == PORT_DMA);
    p0_rdata = r_rd0;
    p1_rdata = r_rd1;
    busy     = (r_state != IDLE);
  end

endmodule
